// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M iterative divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [1:0] RESULT_SRC_DIV = 2'b11;
  function automatic logic [31:0] absVal(input logic [31:0] x, input logic isSigned);
    return (isSigned && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem, quo}.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] nextRem,
  output logic [31:0] nextQuo
);
  logic [32:0] shifted, diff;
  // rem < divisor always holds, so a 33-bit trial difference cannot alias.
  assign shifted = {rem, quo[31]};
  assign diff = shifted - {1'b0, divisor};
  assign nextRem = diff[32] ? shifted[31:0] : diff[31:0];
  assign nextQuo = {quo[30:0], ~diff[32]};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, 33-cycle latency.
// Optional DIV_EARLY_OUT_EN finishes divide-by-zero and signed overflow in one cycle.
module div_unit
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);
  div_state_t state;
  logic [4:0] count;
  logic [31:0] rem, quo, divisor, nextRem, nextQuo, qVal, rVal, finalVal, earlyVal;
  logic negQ, negR, isRem, divZero, ovf;
  logic [2:0] op;
  logic inSigned, inRem, inZero, inOvf;
  // Bit 2 of funct3 does not select anything; force it so the package encodings match.
  assign op = funct3 | 3'b100;
  assign inSigned = (op == F3_DIV) || (op == F3_REM);
  assign inRem = (op == F3_REM) || (op == F3_REMU);
  assign inZero = b == 32'd0;
  assign inOvf = inSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign earlyVal = inZero ? (inRem ? a : 32'hFFFF_FFFF) : (inRem ? 32'd0 : 32'h8000_0000);
  div_step step (.rem(rem), .quo(quo), .divisor(divisor), .nextRem(nextRem), .nextQuo(nextQuo));
  // With a zero divisor the remainder path naturally reproduces a after sign restore.
  assign qVal = divZero ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : (negQ ? -nextQuo : nextQuo);
  assign rVal = ovf ? 32'd0 : (negR ? -nextRem : nextRem);
  assign finalVal = isRem ? rVal : qVal;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= 32'd0;
      count <= 5'd0;
    end else
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem <= 32'd0;
            quo <= absVal(a, inSigned);
            divisor <= absVal(b, inSigned);
            negQ <= inSigned && (a[31] ^ b[31]);
            negR <= inSigned && a[31];
            isRem <= inRem;
            divZero <= inZero;
            ovf <= inOvf;
            count <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
            if (inZero || inOvf) begin
              state <= DONE;
              done <= 1'b1;
              result <= earlyVal;
            end else begin
              state <= CALC;
              busy <= 1'b1;
            end
`else
            state <= CALC;
            busy <= 1'b1;
`endif
          end
        end
        CALC: begin
          rem <= nextRem;
          quo <= nextQuo;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            result <= finalVal;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;
  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic [2:0] funct3;
  logic [31:0] a, b, result;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  div_unit dut (.clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
                .result(result), .busy(busy), .done(done));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return f3[1] ? x : 32'hFFFF_FFFF;
    if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
    if (f3[0]) return f3[1] ? x % y : x / y;
    return f3[1] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
  endfunction
  function automatic int latency(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 0 || (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction
  task automatic waitDone(output int cyc, output int busyCyc, output int overlap);
    cyc = 0;
    busyCyc = 0;
    overlap = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busyCyc++;
      if (busy && done) overlap++;
    end while (!done && cyc < 100);
  endtask
  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    int cyc, bc, ov, lat;
    logic [31:0] exp, held;
    exp = model(f3, x, y);
    lat = latency(f3, x, y);
    funct3 = f3;
    a = x;
    b = y;
    start = 1'b1;
    waitDone(cyc, bc, ov);
    start = 1'b0;
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(lat - 1));
    check({tag, "_overlap"}, 32'(ov), 32'd0);
    held = result;
    a = $urandom;
    b = $urandom;
    @(posedge clk);
    #1;
    check({tag, "_held"}, {result == held, done}, 32'd2);
  endtask
  initial begin
    int cyc, bc, ov;
    logic [2:0] f3;
    logic [31:0] x, y;
    reset = 1'b1;
    start = 1'b0;
    funct3 = 3'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {result[30:0], busy}, {done, 31'd0});
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    runOp("divu_100_7", F3_DIVU, 32'd100, 32'd7);
    runOp("remu_100_7", F3_REMU, 32'd100, 32'd7);
    runOp("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
    runOp("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2);
    runOp("remu_m7_2", F3_REMU, 32'hFFFF_FFF9, 32'd2);
    runOp("div_by0", F3_DIV, 32'hFFFF_FFF9, 32'd0);
    runOp("rem_by0", F3_REM, 32'hFFFF_FFF9, 32'd0);
    runOp("divu_by0", F3_DIVU, 32'hFFFF_FFF9, 32'd0);
    runOp("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("divu_ovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("div_bit2", 3'b000, 32'd50, 32'hFFFF_FFFB);
    funct3 = F3_DIVU;
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midcalc_reset", {result[29:0], busy, done}, 32'd0);
    reset = 1'b0;
    runOp("after_reset", F3_DIVU, 32'd9, 32'd3);
    funct3 = F3_DIVU;
    a = 32'd20;
    b = 32'd4;
    start = 1'b1;
    waitDone(cyc, bc, ov);
    check("b2b_first", result, 32'd5);
    check("b2b_first_lat", 32'(cyc), 32'd33);
    a = 32'd21;
    b = 32'd5;
    waitDone(cyc, bc, ov);
    start = 1'b0;
    check("b2b_second", result, 32'd4);
    check("b2b_second_lat", 32'(cyc), 32'd34);
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: y = $urandom;
      endcase
      if (i % 10 == 3) x = 32'h8000_0000;
      runOp($sformatf("rand%0d_f%0d_%h_%h", i, f3, x, y), f3, x, y);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider for the EX stage: executes DIV, DIVU, REM and REMU on the forwarded EX operands (SrcAE, SrcBE) and returns a 32-bit result that the datapath latches into the EX/MEM register. It is a peer of the multiplier and feeds the same writeback path. The datapath and hazard unit use its done pulse to hold IF/ID/EX and EX/MEM while a division is in flight.

## Interface
- No parameters. Width is fixed at 32 bits (RV32).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level: a divide op occupies EX (ResultSrcE divide encoding); must not depend combinationally on any output of this block.
- funct3  in  3  funct3E. Bit 1: 1 = remainder, 0 = quotient. Bit 0: 1 = unsigned, 0 = signed. Bit 2 is ignored.
- a  in  32  dividend (SrcAE).
- b  in  32  divisor (SrcBE).
- result  out  32  quotient or remainder; valid while done=1 and held until the next capture.
- busy  out  1  registered; 1 in CALC.
- done  out  1  registered; one-cycle pulse in DONE.
- Hazard stall term: start & ~done.

## Operation
- FSM states: IDLE, CALC, DONE. Reset sends the FSM to IDLE.
- IDLE:
  - On start=1, capture the operands and go to CALC.
  - Capture stores |a|, |b| (or raw values if unsigned), the quotient sign (a[31]^b[31], signed only), the remainder sign (a[31], signed only), and funct3[1:0].
  - Iteration count clears to 0.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract rem - divisor using a 33-bit difference; if non-negative, keep it and set the quotient LSB.
  - After step 31, the count wraps and the FSM goes to DONE.
- Final result is written on the CALC→DONE edge:
  - Signed: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. The selected value goes to result.
- Special cases override the computed value, both with and without the macro:
  - b==0: quotient 0xFFFFFFFF for both signed and unsigned; remainder = a unmodified.
  - Signed a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- Back-to-back: if start is still high in the IDLE cycle after DONE, it is a new instruction (the pipeline advanced on done) and is captured.
- Reset at any time, including mid-CALC:
  - Next cycle: state IDLE, busy=0, done=0, result=0, count=0.
  - The in-flight operation is discarded.
- Reset values of all outputs: result=0, busy=0, done=0.

## Timing
- Normal latency, with start first high in cycle 0 (IDLE):
  - CALC occupies cycles 1–32.
  - done=1 in cycle 33; the pipeline stalls for cycles 0–32.
- busy is high in cycles 1–32.
- done never coincides with busy.
- result is stable from the done cycle until the next capture edge.
- No combinational path from any input to busy, done or result.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - In IDLE, b==0 or signed overflow is detected at capture; the FSM goes directly to DONE with the override result.
  - done arrives in cycle 1 (1 stall cycle).
- Undefined: special cases still take the full 33-cycle latency; the override is applied on the CALC→DONE edge. Results are identical either way.

## Structure
- Shared package holds:
  - div_state_t enum (IDLE, CALC, DONE).
  - funct3 constants F3_DIV=3'b100, F3_DIVU=3'b101, F3_REM=3'b110, F3_REMU=3'b111.
  - Result-select encoding for the divide path in the writeback mux.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; the state registers live in div_unit.

## Test plan
- DIVU a=100, b=7 → result 14, done in cycle 33. REMU with the same operands → 2.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. REMU with the same operands → 0xFFFFFFF9 % 2 = 1.
- Divide by zero, a=0xFFFFFFF9, b=0:
  - DIV → 0xFFFFFFFF; REM → 0xFFFFFFF9.
  - done in cycle 1 with DIV_EARLY_OUT_EN, cycle 33 without.
- Signed overflow, a=0x80000000, b=0xFFFFFFFF: DIV → 0x80000000, REM → 0. DIVU with the same operands → 0x00000000.
- Reset asserted in cycle 10 of CALC → next cycle busy=0, done=0, result=0. A new DIVU 9/3 then returns 3 with normal latency.
- start held high across done with new operands (20/4 then 21/5, DIVU):
  - First result 5 on the first done.
  - Second op captured the cycle after done; result 4 at 34 cycles after the first done.
